hx711_tare_sequencer: RTL and testbench
=======================================

# hx711_tare_sequencer

Sequences the HX711 load-cell driver and owns the zero-offset (tare) path of the scale. On reset it power-cycles the sensor and discards the settling conversions. It then averages a power-of-two block of samples into a tare offset and streams offset-corrected net readings downstream. A watchdog detects a silent sensor and retries with a power-down cycle, up to a limit, then latches a fault. It sits between the driver's sample strobe (already synchronised and edge-detected into the 100 MHz domain) and the averaging/display logic.

## Interface

Parameters:
- PD_CYCLES, 10_000: cycles `drv_powerdown` is held high (100 µs at 100 MHz; HX711 requires >60 µs).
- SETTLE_SAMPLES, 4: conversions discarded after every power-up.
- AVG_LOG2, 4: tare block is 2^AVG_LOG2 samples.
- TIMEOUT_CYCLES, 50_000_000: maximum gap between `sample_valid` pulses before a timeout.
- MAX_RETRIES, 3: consecutive timeouts tolerated before fault.

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  reset, asynchronous, active-high
- sample_valid  in  1  one-cycle strobe, new conversion on `sample_data`
- sample_data  in  24  signed two's-complement conversion
- tare_req  in  1  one-cycle tare request
- drv_start  out  1  enables driver conversions
- drv_powerdown  out  1  forces the driver's SCLK high (sensor power-down)
- net_value  out  25  signed, `sample_data - offset`
- net_valid  out  1  one-cycle strobe qualifying `net_value`
- offset  out  24  signed current tare offset
- offset_valid  out  1  offset has been acquired at least once since reset
- busy  out  1  high in every state except ST_RUN
- fault  out  1  sticky, sensor declared dead
- state_code  out  3  encoding: ST_PWRDN=0, ST_SETTLE=1, ST_TARE=2, ST_RUN=3, ST_FAULT=4 (LED debug)

## Operation

- All outputs reset to 0 and the state to ST_PWRDN. Internal state also resets: counters, accumulator, `tare_pending`, retry count.
- ST_PWRDN: `drv_powerdown`=1, `drv_start`=0. After PD_CYCLES cycles, go to ST_SETTLE with the watchdog cleared.
- ST_SETTLE: `drv_start`=1. Count and discard SETTLE_SAMPLES samples. On the last one, go to ST_TARE if `!offset_valid || tare_pending`, else ST_RUN.
- ST_TARE: `drv_start`=1. On each sample, `acc += sign-extend(sample_data)`; acc is 24+AVG_LOG2 bits, signed.
  - On the 2^AVG_LOG2-th sample, at the same edge: `offset <= (acc + sample) >>> AVG_LOG2` (arithmetic shift, truncating toward −∞), `offset_valid`=1, clear `tare_pending` and acc, go to ST_RUN.
- ST_RUN: on each sample, register `net_value = sext25(sample_data) - sext25(offset)` and pulse `net_valid`. No saturation is needed, since 25 bits cover the full range.
- Watchdog runs in ST_SETTLE, ST_TARE and ST_RUN:
  - It clears on `sample_valid` and on state entry.
  - On reaching TIMEOUT_CYCLES-1 it increments the retry count.
  - If the retry count is below MAX_RETRIES, go to ST_PWRDN, keeping `offset`/`offset_valid` and abandoning any partial tare; otherwise go to ST_FAULT.
- The retry count clears on any `sample_valid`.
- ST_FAULT: `fault`=1, `drv_start`=0, `drv_powerdown`=1. This is terminal; only reset exits it.
- `tare_req` handling by state:
  - ST_RUN: go to ST_TARE next cycle with acc and count cleared.
  - ST_TARE: restart accumulation (acc and count cleared).
  - ST_PWRDN or ST_SETTLE: set `tare_pending`.
  - ST_FAULT: ignored.

## Timing

- `net_valid` and `net_value` appear exactly 1 cycle after `sample_valid` in ST_RUN. `net_value` holds until the next strobe.
- New `offset` is visible 1 cycle after the final tare sample. The first ST_RUN sample uses the new offset.
- Simultaneous events:
  - `sample_valid` with `tare_req` in ST_RUN: that sample produces a net output and is not counted in the tare.
  - `sample_valid` with `tare_req` in ST_TARE: the restart wins and the sample is discarded.
  - `sample_valid` on the timeout cycle: the sample wins, with no timeout.
- `sample_valid` during ST_PWRDN or ST_FAULT is ignored.
- Asynchronous reset mid-tare discards the partial accumulation and returns `offset_valid` to 0.

## Test plan

Bench parameters: PD_CYCLES=8, SETTLE_SAMPLES=2, AVG_LOG2=2, TIMEOUT_CYCLES=100, MAX_RETRIES=2.

- Boot:
  - Stimulus: release reset, then samples 0x000010, 0x000020 (settle), then 100, 102, 104, 106.
  - Required response: `drv_powerdown` high for 8 cycles; `offset`=103 one cycle after the 4th tare sample; `offset_valid`=1; `state_code`=3.
- Negative tare:
  - Stimulus: tare samples −5, −6, −6, −6.
  - Required response: `offset`=−6 (−23>>>2); then sample −1 gives `net_value`=+5 one cycle later.
- Range extremes:
  - Stimulus: `offset`=−8388608, sample 0x7FFFFF.
  - Required response: `net_value`=16777215, no wrap.
- Re-tare collision:
  - Stimulus: `tare_req` together with `sample_valid` (value 500) in ST_RUN.
  - Required response: `net_valid` with 500−`offset`; state 2 next cycle; acc empty.
- Timeout and fault:
  - Stimulus: stop samples in ST_RUN.
  - Required response: after 100 cycles, ST_PWRDN with `offset` retained.
  - Stimulus: still no samples after the retry.
  - Required response: `fault`=1 and `state_code`=4 after the second timeout.
  - Stimulus: one sample after the first retry.
  - Required response: retry count clears and the block returns to ST_RUN without re-tare.
- Reset mid-tare:
  - Stimulus: assert reset after 2 of 4 tare samples.
  - Required response: all outputs 0 immediately; a fresh boot sequence repeats.

Source files
------------

// File: rtl/hx711_tare_sequencer.sv
// HX711 sequencer: power-cycles the sensor, discards settling conversions, averages a tare
// offset and streams offset-corrected readings, with a retrying watchdog for a silent sensor.
module hx711_tare_sequencer #(
    parameter int unsigned PD_CYCLES      = 10_000,
    parameter int unsigned SETTLE_SAMPLES = 4,
    parameter int unsigned AVG_LOG2       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [23:0] sample_data,
    input  logic               tare_req,
    output logic               drv_start,
    output logic               drv_powerdown,
    output logic signed [24:0] net_value,
    output logic               net_valid,
    output logic signed [23:0] offset,
    output logic               offset_valid,
    output logic               busy,
    output logic               fault,
    output logic [2:0]         state_code
);

    localparam int unsigned PD_W  = $clog2(PD_CYCLES + 1);
    localparam int unsigned SE_W  = $clog2(SETTLE_SAMPLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RT_W  = $clog2(MAX_RETRIES + 1);
    localparam int unsigned ACC_W = 24 + AVG_LOG2;

    localparam logic [PD_W-1:0] PD_LAST     = PD_W'(PD_CYCLES - 1);
    localparam logic [SE_W-1:0] SETTLE_LAST = SE_W'(SETTLE_SAMPLES - 1);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_LAST     = RT_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_PWRDN  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TARE   = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t                    state, next_state;
    logic [PD_W-1:0]           pd_count;
    logic [SE_W-1:0]           settle_count;
    logic [WD_W-1:0]           wd_count;
    logic [RT_W-1:0]           retry_count;
    logic [AVG_LOG2-1:0]       tare_count;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      tare_pending;
    logic                      active;
    logic                      wd_expire;

    assign state_code = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_PWRDN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        active     = (state == ST_SETTLE) || (state == ST_TARE) || (state == ST_RUN);
        wd_expire  = active && !sample_valid && (wd_count == WD_LAST);
        sample_ext = {{AVG_LOG2{sample_data[23]}}, sample_data};
        acc_sum    = acc + sample_ext;
        case (state)
            ST_PWRDN:  if (drv_powerdown && pd_count == PD_LAST) next_state = ST_SETTLE;
            ST_SETTLE: if (sample_valid && settle_count == SETTLE_LAST)
                           next_state = (!offset_valid || tare_pending || tare_req) ? ST_TARE : ST_RUN;
            ST_TARE:   if (!tare_req && sample_valid && tare_count == '1) next_state = ST_RUN;
            ST_RUN:    if (tare_req) next_state = ST_TARE;
            ST_FAULT:  next_state = ST_FAULT;
            default:   next_state = ST_PWRDN;
        endcase
        if (wd_expire) next_state = (retry_count < RT_LAST) ? ST_PWRDN : ST_FAULT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drv_start     <= 1'b0;
            drv_powerdown <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            net_value     <= '0;
            net_valid     <= 1'b0;
            offset        <= '0;
            offset_valid  <= 1'b0;
            pd_count      <= '0;
            settle_count  <= '0;
            wd_count      <= '0;
            retry_count   <= '0;
            tare_count    <= '0;
            acc           <= '0;
            tare_pending  <= 1'b0;
        end else begin
            drv_powerdown <= (next_state == ST_PWRDN) || (next_state == ST_FAULT);
            drv_start     <= (next_state == ST_SETTLE) || (next_state == ST_TARE) || (next_state == ST_RUN);
            busy          <= (next_state != ST_RUN);
            fault         <= (next_state == ST_FAULT);
            net_valid     <= 1'b0;

            // Power-down time is counted only while the registered pin is already high,
            // so the pulse is PD_CYCLES long both after reset and on a retry.
            if (state == ST_PWRDN && drv_powerdown) pd_count <= pd_count + 1'b1;
            else                                    pd_count <= '0;

            if (!active || next_state != state || sample_valid) wd_count <= '0;
            else                                                wd_count <= wd_count + 1'b1;

            if (wd_expire)                  retry_count <= retry_count + 1'b1;
            else if (active && sample_valid) retry_count <= '0;

            if (state != ST_SETTLE)
                settle_count <= '0;
            else if (sample_valid)
                settle_count <= (settle_count == SETTLE_LAST) ? '0 : settle_count + 1'b1;

            if (tare_req && (state == ST_PWRDN || state == ST_SETTLE)) tare_pending <= 1'b1;

            if (state != ST_TARE || tare_req) begin
                acc        <= '0;
                tare_count <= '0;
            end else if (sample_valid) begin
                if (tare_count == '1) begin
                    offset       <= 24'(acc_sum >>> AVG_LOG2);
                    offset_valid <= 1'b1;
                    tare_pending <= 1'b0;
                    acc          <= '0;
                    tare_count   <= '0;
                end else begin
                    acc        <= acc_sum;
                    tare_count <= tare_count + 1'b1;
                end
            end

            if (state == ST_RUN && sample_valid) begin
                net_value <= {sample_data[23], sample_data} - {offset[23], offset};
                net_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hx711_tare_sequencer.sv
// Directed self-checking bench for hx711_tare_sequencer: boot, tare averaging, range extremes,
// tare collisions, watchdog retry/fault and asynchronous reset mid-tare.
module tb_hx711_tare_sequencer;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [23:0] sample_data = '0;
    logic               tare_req = 1'b0;
    logic               drv_start, drv_powerdown, net_valid, offset_valid, busy, fault;
    logic signed [24:0] net_value;
    logic signed [23:0] offset;
    logic [2:0]         state_code;

    int checks   = 0;
    int failures = 0;
    int n;

    hx711_tare_sequencer #(
        .PD_CYCLES(8),
        .SETTLE_SAMPLES(2),
        .AVG_LOG2(2),
        .TIMEOUT_CYCLES(100),
        .MAX_RETRIES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .tare_req(tare_req),
        .drv_start(drv_start),
        .drv_powerdown(drv_powerdown),
        .net_value(net_value),
        .net_valid(net_valid),
        .offset(offset),
        .offset_valid(offset_valid),
        .busy(busy),
        .fault(fault),
        .state_code(state_code)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic tr);
        @(negedge clock);
        sample_valid = 1'b1;
        sample_data  = 24'(d);
        tare_req     = tr;
        @(negedge clock);
        sample_valid = 1'b0;
        tare_req     = 1'b0;
    endtask

    task automatic req_tare();
        @(negedge clock);
        tare_req = 1'b1;
        @(negedge clock);
        tare_req = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, output int cnt);
        cnt = 0;
        while (state_code !== s && cnt <= limit) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    // Releases reset and measures the power-down pulse that follows.
    task automatic boot(input string tag);
        int pd_n;
        pd_n = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (drv_powerdown) pd_n++;
            else if (pd_n != 0) break;
        end
        chk({tag, "_pd_len"}, pd_n, 8);
        chk({tag, "_settle_state"}, state_code, 1);
        chk({tag, "_drv_start"}, drv_start, 1);
    endtask

    initial begin
        #12;
        chk("rst_state", state_code, 0);
        chk("rst_powerdown", drv_powerdown, 0);
        chk("rst_busy", busy, 0);
        chk("rst_offset_valid", offset_valid, 0);

        // Boot and first tare
        boot("boot");
        chk("boot_busy", busy, 1);
        send(16, 0);
        send(32, 0);
        chk("boot_tare_state", state_code, 2);
        send(100, 0);
        send(102, 0);
        send(104, 0);
        chk("boot_partial_valid", offset_valid, 0);
        send(106, 0);
        chk("boot_offset", offset, 103);
        chk("boot_offset_valid", offset_valid, 1);
        chk("boot_run_state", state_code, 3);
        chk("boot_run_busy", busy, 0);
        send(200, 0);
        chk("run_net_valid", net_valid, 1);
        chk("run_net", net_value, 97);

        // Negative tare rounds toward minus infinity
        req_tare();
        chk("neg_tare_state", state_code, 2);
        send(-5, 0);
        send(-6, 0);
        send(-6, 0);
        send(-6, 0);
        chk("neg_offset", offset, -6);
        send(-1, 0);
        chk("neg_net", net_value, 5);
        @(negedge clock);
        chk("neg_strobe_low", net_valid, 0);
        chk("neg_net_hold", net_value, 5);

        // Range extremes
        req_tare();
        for (int i = 0; i < 4; i++) send(-8388608, 0);
        chk("min_offset", offset, -8388608);
        send(8388607, 0);
        chk("max_net", net_value, 16777215);
        req_tare();
        for (int i = 0; i < 4; i++) send(8388607, 0);
        chk("max_offset", offset, 8388607);
        send(-8388608, 0);
        chk("min_net", net_value, -16777215);

        // Tare request colliding with samples in RUN and in TARE
        send(500, 1);
        chk("coll_net_valid", net_valid, 1);
        chk("coll_net", net_value, 500 - 8388607);
        chk("coll_state", state_code, 2);
        send(1000, 0);
        send(1000, 0);
        send(7777, 1);
        chk("restart_state", state_code, 2);
        chk("restart_no_net", net_valid, 0);
        send(8, 0);
        send(8, 0);
        send(8, 0);
        send(12, 0);
        chk("restart_offset", offset, 9);
        send(20, 0);
        chk("restart_net", net_value, 11);

        // Watchdog: timeout, recover with a sample, timeout again, then fault
        wait_state(3'd0, 200, n);
        chk("to1_cycles", n, 100);
        chk("to1_offset", offset, 9);
        chk("to1_offset_valid", offset_valid, 1);
        chk("to1_powerdown", drv_powerdown, 1);
        wait_state(3'd1, 20, n);
        chk("to1_pd_cycles", n, 8);
        send(1, 0);
        send(2, 0);
        chk("recover_state", state_code, 3);
        chk("recover_offset", offset, 9);
        wait_state(3'd0, 200, n);
        chk("to2_cycles", n, 100);
        chk("to2_no_fault", fault, 0);
        wait_state(3'd1, 20, n);
        chk("to2_pd_cycles", n, 8);
        wait_state(3'd4, 200, n);
        chk("fault_cycles", n, 100);
        chk("fault_flag", fault, 1);
        chk("fault_powerdown", drv_powerdown, 1);
        chk("fault_drv_start", drv_start, 0);
        send(5, 0);
        chk("fault_sticky", state_code, 4);
        chk("fault_no_net", net_valid, 0);

        // Asynchronous reset out of fault
        #2 reset = 1'b1;
        #1;
        chk("rst2_fault", fault, 0);
        chk("rst2_offset", offset, 0);
        chk("rst2_state", state_code, 0);
        chk("rst2_powerdown", drv_powerdown, 0);

        // Reset mid-tare discards the partial accumulation
        boot("boot2");
        send(16, 0);
        send(32, 0);
        send(400, 0);
        send(400, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst3_offset_valid", offset_valid, 0);
        chk("rst3_state", state_code, 0);
        chk("rst3_drv_start", drv_start, 0);
        boot("boot3");
        send(16, 0);
        send(32, 0);
        chk("boot3_tare_state", state_code, 2);
        send(0, 0);
        send(0, 0);
        send(4, 0);
        send(4, 0);
        chk("boot3_offset", offset, 2);
        chk("boot3_run_state", state_code, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
